// File: rtl/bird_launch_ctrl.sv
// Bird launch sequencer: arms on newGame, requests a launch on a fire edge,
// tracks the flight, runs a frame-based cooldown and decides win/lose.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | after reset, everything parked until newGame
// ARMED     | waiting for a fire edge
// REQUEST   | showBird raised, waiting for launch acknowledge or timeout
// IN_FLIGHT | bird in the air, waiting for it to land or the watchdog
// COOLDOWN  | frame countdown before the next shot / round verdict
// WIN       | all pigs destroyed, held until newGame
// LOSE      | out of birds with pigs left, held until newGame

module bird_launch_ctrl #(
    parameter int NUM_BIRDS          = 5,
    parameter int NUM_PIGS           = 3,
    parameter int COOLDOWN_FRAMES    = 30,
    parameter int REQ_TIMEOUT_FRAMES = 60,
    parameter int MAX_FLIGHT_FRAMES  = 255
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       newGame,
    input  logic       fireKey,
    input  logic       shootBirdPulse,
    input  logic       displayBird,
    input  logic       pigHitPulse,
    output logic       showBird,
    output logic [2:0] birdsLeft,
    output logic [2:0] pigsLeft,
    output logic [7:0] launchCount,
    output logic       armed,
    output logic       gameOver,
    output logic       levelWin,
    output logic       flightAbort,
    output logic [2:0] stateCode
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ARMED     = 3'd1;
    localparam logic [2:0] REQUEST   = 3'd2;
    localparam logic [2:0] IN_FLIGHT = 3'd3;
    localparam logic [2:0] COOLDOWN  = 3'd4;
    localparam logic [2:0] WIN       = 3'd5;
    localparam logic [2:0] LOSE      = 3'd6;

    // One frame counter serves both the request timeout and the flight watchdog.
    localparam int FRAME_MAX = (REQ_TIMEOUT_FRAMES > MAX_FLIGHT_FRAMES) ?
                               REQ_TIMEOUT_FRAMES : MAX_FLIGHT_FRAMES;
    localparam int FW = (FRAME_MAX < 2) ? 1 : $clog2(FRAME_MAX + 1);
    localparam int CW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    localparam logic [FW:0]   REQ_LIM    = (FW + 1)'(REQ_TIMEOUT_FRAMES);
    localparam logic [FW:0]   FLIGHT_LIM = (FW + 1)'(MAX_FLIGHT_FRAMES);
    localparam logic [CW-1:0] CD_LOAD    = CW'(COOLDOWN_FRAMES);

    logic [2:0]    state, state_nxt;
    logic          fire_key_d;
    logic          fire_edge;
    logic [FW-1:0] frame_cnt, frame_nxt;
    logic [FW:0]   frame_inc;
    logic [CW-1:0] cd_cnt, cd_nxt;
    logic          seen_high, seen_nxt;
    logic [2:0]    birds_nxt, pigs_nxt;
    logic [7:0]    launch_nxt;
    logic          abort_nxt;
    logic          pig_window;

    assign fire_edge  = fireKey & ~fire_key_d;
    // Extra bit so a reached limit is visible before the counter would wrap.
    assign frame_inc  = {1'b0, frame_cnt} + (FW + 1)'(startOfFrame);
    assign pig_window = (state == REQUEST) || (state == IN_FLIGHT) || (state == COOLDOWN);
    assign stateCode  = state;

    // Next-state, counter and score computation; newGame overrides everything.
    always_comb begin
        state_nxt  = state;
        frame_nxt  = frame_cnt;
        cd_nxt     = cd_cnt;
        seen_nxt   = seen_high;
        birds_nxt  = birdsLeft;
        pigs_nxt   = pigsLeft;
        launch_nxt = launchCount;
        abort_nxt  = 1'b0;

        if (pigHitPulse && pig_window && (pigsLeft != 3'd0))
            pigs_nxt = pigsLeft - 3'd1;

        if (newGame) begin
            state_nxt = ARMED;
            birds_nxt = 3'(NUM_BIRDS);
            pigs_nxt  = 3'(NUM_PIGS);
            frame_nxt = '0;
            cd_nxt    = '0;
            seen_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ARMED: begin
                    if (fire_edge && (birdsLeft != 3'd0)) begin
                        state_nxt = REQUEST;
                        frame_nxt = '0;
                    end
                end
                REQUEST: begin
                    // A late acknowledge still beats the timeout on the same edge.
                    if (shootBirdPulse) begin
                        state_nxt  = IN_FLIGHT;
                        birds_nxt  = birdsLeft - 3'd1;
                        launch_nxt = launchCount + 8'd1;
                        frame_nxt  = '0;
                        seen_nxt   = 1'b0;
                    end else if (frame_inc >= REQ_LIM) begin
                        state_nxt = ARMED;
                        frame_nxt = '0;
                    end else begin
                        frame_nxt = frame_inc[FW-1:0];
                    end
                end
                IN_FLIGHT: begin
                    if (displayBird)
                        seen_nxt = 1'b1;
                    if (seen_high && !displayBird) begin
                        state_nxt = COOLDOWN;
                        cd_nxt    = CD_LOAD;
                        frame_nxt = '0;
                        seen_nxt  = 1'b0;
                    end else if (frame_inc >= FLIGHT_LIM) begin
                        state_nxt = COOLDOWN;
                        cd_nxt    = CD_LOAD;
                        frame_nxt = '0;
                        seen_nxt  = 1'b0;
                        abort_nxt = 1'b1;
                    end else begin
                        frame_nxt = frame_inc[FW-1:0];
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == '0) begin
                        if (pigsLeft == 3'd0)
                            state_nxt = WIN;
                        else if (birdsLeft == 3'd0)
                            state_nxt = LOSE;
                        else
                            state_nxt = ARMED;
                    end else if (startOfFrame) begin
                        cd_nxt = cd_cnt - CW'(1);
                    end
                end
                WIN, LOSE: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, counters and all outputs registered; reset parks everything at zero.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            fire_key_d  <= 1'b0;
            frame_cnt   <= '0;
            cd_cnt      <= '0;
            seen_high   <= 1'b0;
            showBird    <= 1'b0;
            birdsLeft   <= 3'd0;
            pigsLeft    <= 3'd0;
            launchCount <= 8'd0;
            armed       <= 1'b0;
            gameOver    <= 1'b0;
            levelWin    <= 1'b0;
            flightAbort <= 1'b0;
        end else begin
            state       <= state_nxt;
            fire_key_d  <= fireKey;
            frame_cnt   <= frame_nxt;
            cd_cnt      <= cd_nxt;
            seen_high   <= seen_nxt;
            showBird    <= (state_nxt == REQUEST);
            birdsLeft   <= birds_nxt;
            pigsLeft    <= pigs_nxt;
            launchCount <= launch_nxt;
            armed       <= (state_nxt == ARMED);
            gameOver    <= (state_nxt == LOSE);
            levelWin    <= (state_nxt == WIN);
            flightAbort <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_bird_launch_ctrl.sv
// Bench for bird_launch_ctrl: directed round scenarios plus randomized games
// checked against a per-launch score model. A second instance with a zero
// cooldown shares the stimulus for the one-clock cooldown case.

module tb_bird_launch_ctrl;

    localparam int NB = 5, NP = 3, CD = 30;
    localparam int S_IDLE = 0, S_ARMED = 1, S_REQ = 2, S_FLY = 3, S_CD = 4, S_WIN = 5, S_LOSE = 6;

    logic clk = 1'b0;
    logic resetN, startOfFrame, newGame, fireKey, shootBirdPulse, displayBird, pigHitPulse;

    logic       showBird, armed, gameOver, levelWin, flightAbort;
    logic [2:0] birdsLeft, pigsLeft, stateCode;
    logic [7:0] launchCount;

    logic       showBird0, armed0, gameOver0, levelWin0, flightAbort0;
    logic [2:0] birdsLeft0, pigsLeft0, stateCode0;
    logic [7:0] launchCount0;

    int n_assert = 0;
    int n_fail   = 0;
    int m_birds  = 0;
    int m_pigs   = 0;
    int m_launch = 0;

    bird_launch_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .newGame(newGame),
        .fireKey(fireKey), .shootBirdPulse(shootBirdPulse), .displayBird(displayBird),
        .pigHitPulse(pigHitPulse), .showBird(showBird), .birdsLeft(birdsLeft),
        .pigsLeft(pigsLeft), .launchCount(launchCount), .armed(armed),
        .gameOver(gameOver), .levelWin(levelWin), .flightAbort(flightAbort),
        .stateCode(stateCode)
    );

    bird_launch_ctrl #(.COOLDOWN_FRAMES(0)) dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .newGame(newGame),
        .fireKey(fireKey), .shootBirdPulse(shootBirdPulse), .displayBird(displayBird),
        .pigHitPulse(pigHitPulse), .showBird(showBird0), .birdsLeft(birdsLeft0),
        .pigsLeft(pigsLeft0), .launchCount(launchCount0), .armed(armed0),
        .gameOver(gameOver0), .levelWin(levelWin0), .flightAbort(flightAbort0),
        .stateCode(stateCode0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1; tick();
            startOfFrame = 1'b0; tick();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int verdict();
        if (m_pigs == 0)  return S_WIN;
        if (m_birds == 0) return S_LOSE;
        return S_ARMED;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(stateCode), S_IDLE);
        check({tag, "_show"},  32'(showBird), 0);
        check({tag, "_birds"}, 32'(birdsLeft), 0);
        check({tag, "_pigs"},  32'(pigsLeft), 0);
        check({tag, "_launch"}, 32'(launchCount), 0);
        check({tag, "_armed"}, 32'(armed), 0);
        check({tag, "_over"},  32'(gameOver), 0);
        check({tag, "_win"},   32'(levelWin), 0);
        check({tag, "_abort"}, 32'(flightAbort), 0);
    endtask

    task automatic fire();
        fireKey = 1'b1; tick();
        fireKey = 1'b0;
    endtask

    task automatic new_game();
        newGame = 1'b1; tick();
        newGame = 1'b0;
        m_birds = NB;
        m_pigs  = NP;
        check("ng_state", 32'(stateCode), S_ARMED);
        check("ng_birds", 32'(birdsLeft), NB);
        check("ng_pigs",  32'(pigsLeft), NP);
        check("ng_flags", {29'd0, armed, gameOver, levelWin}, 32'b100);
    endtask

    task automatic do_flight(input int ack_dly, input int fly_frames, input int hits);
        int exp_st;
        fire();
        check("fl_req", 32'(stateCode), S_REQ);
        repeat (ack_dly - 1) tick();
        check("fl_show", 32'(showBird), 1);
        shootBirdPulse = 1'b1; tick();
        shootBirdPulse = 1'b0;
        m_birds--;
        m_launch = (m_launch + 1) % 256;
        check("fl_inflight", 32'(stateCode), S_FLY);
        check("fl_show_off", 32'(showBird), 0);
        check("fl_birds", 32'(birdsLeft), m_birds);
        check("fl_launch", 32'(launchCount), m_launch);
        displayBird = 1'b1; tick();
        frames(fly_frames);
        for (int h = 0; h < hits; h++) begin
            pigHitPulse = 1'b1; tick();
            pigHitPulse = 1'b0; tick();
            if (m_pigs > 0) m_pigs--;
        end
        displayBird = 1'b0; tick();
        check("fl_cooldown", 32'(stateCode), S_CD);
        check("fl_pigs", 32'(pigsLeft), m_pigs);
        frames(CD);
        exp_st = verdict();
        check("fl_verdict", 32'(stateCode), exp_st);
        check("fl_over", 32'(gameOver), (exp_st == S_LOSE) ? 1 : 0);
        check("fl_win", 32'(levelWin), (exp_st == S_WIN) ? 1 : 0);
        check("fl_armed", 32'(armed), (exp_st == S_ARMED) ? 1 : 0);
    endtask

    initial begin
        int st;
        resetN = 1'b0; startOfFrame = 1'b0; newGame = 1'b0; fireKey = 1'b0;
        shootBirdPulse = 1'b0; displayBird = 1'b0; pigHitPulse = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        resetN = 1'b1; tick();

        // Fire in IDLE is dropped.
        fire(); tick();
        check("idle_fire", 32'(stateCode), S_IDLE);

        new_game();
        pigHitPulse = 1'b1; tick(); pigHitPulse = 1'b0;
        check("armed_pig_ignored", 32'(pigsLeft), NP);

        // Ack three clocks after the fire edge: showBird high for exactly 3 clocks.
        fire();
        check("a_show1", 32'(showBird), 1);
        tick();
        check("a_show2", 32'(showBird), 1);
        tick();
        check("a_show3", 32'(showBird), 1);
        shootBirdPulse = 1'b1; tick(); shootBirdPulse = 1'b0;
        m_birds = NB - 1; m_launch = 1;
        check("a_show_off", 32'(showBird), 0);
        check("a_birds", 32'(birdsLeft), m_birds);
        check("a_launch", 32'(launchCount), m_launch);
        check("a_state", 32'(stateCode), S_FLY);

        // Landing, zero-cooldown instance leaves after one clock.
        displayBird = 1'b1; tick();
        displayBird = 1'b0; tick();
        check("land_state", 32'(stateCode), S_CD);
        check("cd0_state_in", 32'(stateCode0), S_CD);
        tick();
        check("cd0_state_out", 32'(stateCode0), S_ARMED);
        check("cd0_armed", 32'(armed0), 1);
        check("cd_hold", 32'(stateCode), S_CD);
        fire();
        frames(CD - 1);
        check("cd_29", 32'(stateCode), S_CD);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        check("cd_zero", 32'(stateCode), S_CD);
        tick();
        check("cd_exit", 32'(stateCode), S_ARMED);
        tick();
        check("cd_fire_dropped", 32'(stateCode), S_ARMED);

        // Request timeout on the 60th frame.
        fire();
        frames(59);
        check("to_59_state", 32'(stateCode), S_REQ);
        check("to_59_show", 32'(showBird), 1);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        check("to_state", 32'(stateCode), S_ARMED);
        check("to_show", 32'(showBird), 0);
        check("to_birds", 32'(birdsLeft), m_birds);

        // Ack on the same clock as the 60th frame wins.
        fire();
        frames(59);
        startOfFrame = 1'b1; shootBirdPulse = 1'b1; tick();
        startOfFrame = 1'b0; shootBirdPulse = 1'b0;
        m_birds--; m_launch++;
        check("to_ack_state", 32'(stateCode), S_FLY);
        check("to_ack_birds", 32'(birdsLeft), m_birds);
        check("to_ack_launch", 32'(launchCount), m_launch);

        // Watchdog: displayBird stuck high for 255 frames.
        displayBird = 1'b1;
        fire();
        frames(254);
        check("wd_254_state", 32'(stateCode), S_FLY);
        check("wd_254_abort", 32'(flightAbort), 0);
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        check("wd_state", 32'(stateCode), S_CD);
        check("wd_abort", 32'(flightAbort), 1);
        tick();
        check("wd_abort_pulse", 32'(flightAbort), 0);
        displayBird = 1'b0;
        fire();
        frames(CD);
        check("wd_armed", 32'(stateCode), S_ARMED);
        tick();
        check("wd_fire_dropped", 32'(stateCode), S_ARMED);

        // Remaining birds: no win possible, round must end in LOSE.
        for (int i = 0; i < 3; i++)
            do_flight(int'($urandom_range(1, 5)), int'($urandom_range(0, 6)),
                      (m_pigs > 1) ? int'($urandom_range(0, 1)) : 0);
        check("lose_state", 32'(stateCode), S_LOSE);
        check("lose_over", 32'(gameOver), 1);
        repeat (3) tick();
        check("lose_held", 32'(stateCode), S_LOSE);

        // newGame out of LOSE, then win with four hits in one flight.
        new_game();
        do_flight(int'($urandom_range(1, 5)), 2, 4);
        check("win_state", 32'(stateCode), S_WIN);
        check("win_birds", 32'(birdsLeft), NB - 1);
        check("win_pigs", 32'(pigsLeft), 0);
        repeat (3) tick();
        check("win_held", 32'(levelWin), 1);

        // Randomized full rounds against the score model.
        for (int g = 0; g < 3; g++) begin
            new_game();
            st = S_ARMED;
            while (st == S_ARMED) begin
                do_flight(int'($urandom_range(1, 6)), int'($urandom_range(0, 8)),
                          int'($urandom_range(0, 2)));
                st = verdict();
            end
        end

        // Reset mid-REQUEST drops showBird without a clock.
        new_game();
        fire();
        check("mid_show", 32'(showBird), 1);
        resetN = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        resetN = 1'b1;
        tick();
        check("post_rst_state", 32'(stateCode), S_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bird_launch_ctrl.md
BIRD_LAUNCH_CTRL -- requirements
Module: bird_launch_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_BIRDS, 5, birds per round; NUM_PIGS, 3, targets per round; COOLDOWN_FRAMES, 30, frames between hide and next arm; REQ_TIMEOUT_FRAMES, 60, frames to wait for launch acknowledge; MAX_FLIGHT_FRAMES, 255, flight watchdog.
REQ-002 clk  in  1  system clock; all logic SHALL be on posedge clk.
REQ-003 resetN  in  1  reset, asynchronous, active-low.
REQ-004 startOfFrame  in  1  one-clk pulse per video frame.
REQ-005 newGame  in  1  one-clk pulse; (re)starts a round.
REQ-006 fireKey  in  1  level from keyboard; only its rising edge is used.
REQ-007 shootBirdPulse  in  1  one-clk launch acknowledge from the bird motion block.
REQ-008 displayBird  in  1  level from the bird motion block; high while the bird is in flight.
REQ-009 pigHitPulse  in  1  one-clk pulse per destroyed pig.
REQ-010 showBird  out  1  launch request to the bird motion block.
REQ-011 birdsLeft  out  3  unlaunched birds remaining.
REQ-012 pigsLeft  out  3  pigs remaining.
REQ-013 launchCount  out  8  launches acknowledged since reset; wraps 255->0.
REQ-014 armed, gameOver, levelWin  out  1 each  status levels.
REQ-015 flightAbort  out  1  one-clk pulse when the flight watchdog fires.
REQ-016 stateCode  out  3  current state encoding, for debug.

Function
REQ-017 The FSM SHALL have the states IDLE=0, ARMED=1, REQUEST=2, IN_FLIGHT=3, COOLDOWN=4, WIN=5, LOSE=6; stateCode SHALL equal the current state.
REQ-018 fireKey SHALL be registered once; fireEdge = fireKey & ~fireKey_d; an edge outside ARMED SHALL be dropped, not queued.
REQ-019 newGame SHALL have top priority in every state: next clk -> ARMED, birdsLeft=NUM_BIRDS, pigsLeft=NUM_PIGS, showBird=0, gameOver=0, levelWin=0, counters cleared.
REQ-020 IDLE: all outputs held at reset values; exit only on newGame.
REQ-021 ARMED: armed=1; on fireEdge with birdsLeft>0 -> REQUEST with showBird=1 next clk and frameCnt=0.
REQ-022 REQUEST: showBird SHALL stay 1; on shootBirdPulse -> IN_FLIGHT, showBird=0, birdsLeft-1, launchCount+1, frameCnt=0, all on the same edge.
REQ-023 REQUEST timeout: each startOfFrame increments frameCnt; at frameCnt==REQ_TIMEOUT_FRAMES with no shootBirdPulse -> ARMED, showBird=0, birdsLeft unchanged; shootBirdPulse in the same clk SHALL win.
REQ-024 IN_FLIGHT: a seenHigh flag SHALL set when displayBird=1; when seenHigh=1 and displayBird=0 -> COOLDOWN with cdCnt=COOLDOWN_FRAMES.
REQ-025 IN_FLIGHT watchdog: frameCnt increments per startOfFrame; at MAX_FLIGHT_FRAMES -> COOLDOWN, flightAbort=1 for exactly one clk.
REQ-026 COOLDOWN: cdCnt decrements on startOfFrame; at cdCnt==0, next clk: pigsLeft==0 -> WIN; else birdsLeft==0 -> LOSE; else -> ARMED.
REQ-027 COOLDOWN_FRAMES=0 SHALL give a one-clk COOLDOWN.
REQ-028 pigHitPulse SHALL decrement pigsLeft in REQUEST, IN_FLIGHT and COOLDOWN only; it SHALL saturate at 0 and be ignored in other states.
REQ-029 WIN: levelWin=1; LOSE: gameOver=1; both are held until newGame.
REQ-030 All outputs SHALL be registered; counters SHALL never underflow or overflow except launchCount.

Reset
REQ-031 On resetN=0, asynchronously: state=IDLE; showBird=0; birdsLeft=0; pigsLeft=0; launchCount=0; armed=0; gameOver=0; levelWin=0; flightAbort=0; fireKey_d=0; frameCnt=0; cdCnt=0; seenHigh=0.
REQ-032 Reset asserted mid-REQUEST or mid-IN_FLIGHT SHALL drop showBird within the same cycle; after release, state=IDLE.

Verification
REQ-033 newGame, fire edge, shootBirdPulse 3 clk later -> showBird high for exactly 3 clk, birdsLeft 5->4, launchCount=1, state IN_FLIGHT.
REQ-034 Fire edge, no ack for 60 startOfFrame -> state ARMED, showBird=0, birdsLeft=5; ack in the same clk as the 60th frame -> IN_FLIGHT.
REQ-035 displayBird 1 then 0, 30 frames -> ARMED; repeat 5 launches with no hits -> after the 5th cooldown gameOver=1, state=6.
REQ-036 3 pigHitPulses during one flight -> pigsLeft=0 (4th pulse ignored), levelWin=1 after cooldown even though birdsLeft=4.
REQ-037 displayBird stuck high for 255 frames -> flightAbort one-clk pulse, COOLDOWN; fire edges during IN_FLIGHT/COOLDOWN ignored.
REQ-038 resetN low during REQUEST -> showBird=0 immediately, all outputs at reset values; newGame during LOSE -> ARMED with birdsLeft=5.
